// File: rtl/wakeup_tag_broadcast_pkg.sv
// Shared types and defaults for the wakeup tag broadcast transmitter.
// Holds the latency slot record and the latency legality helper.
package wakeup_tag_broadcast_pkg;

    localparam int DEF_ISSUE_LANES = 4;
    localparam int DEF_TAG_WIDTH = 7;
    localparam int DEF_MAX_LAT   = 4;
    localparam int DEF_LAT_WIDTH = 3;

    typedef struct packed {
        logic                     valid;
        logic [DEF_TAG_WIDTH-1:0] tag;
    } wakeup_slot_t;

    function automatic logic lat_legal(input int lat, input int max_lat);
        return (lat >= 1) && (lat <= max_lat);
    endfunction

endpackage

// File: rtl/wakeup_lane_pipe.sv
// One broadcast lane: latency slot shift register with accept logic,
// slot availability and a registered count of pending broadcasts.
module wakeup_lane_pipe
    import wakeup_tag_broadcast_pkg::*;
#(
    parameter int MAX_LAT   = DEF_MAX_LAT,
    parameter int LAT_WIDTH = DEF_LAT_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush_i,
    input  logic                     issue_valid_i,
    input  logic                     issue_dest_valid_i,
    input  logic [DEF_TAG_WIDTH-1:0] issue_tag_i,
    input  logic [LAT_WIDTH-1:0]     issue_lat_i,
    output logic [MAX_LAT-1:0]       slot_free_o,
    output logic                     bcast_valid_o,
    output logic [DEF_TAG_WIDTH-1:0] bcast_tag_o,
    output logic [LAT_WIDTH-1:0]     inflight_o,
    output logic                     error_o
);

    wakeup_slot_t         slot_q [1:MAX_LAT];
    wakeup_slot_t         slot_d [1:MAX_LAT];
    logic                 request;
    logic                 legal;
    logic                 busy;
    logic                 accept;
    logic [LAT_WIDTH-1:0] count_d;

    // A latency-L issue lands in S[L] after the S[L+1] entry shifts down,
    // so S[L+1] is the one that would share its broadcast cycle.
    always_comb begin
        request = issue_valid_i & issue_dest_valid_i & ~flush_i;
        legal   = lat_legal(int'(issue_lat_i), MAX_LAT);
        busy    = 1'b0;
        for (int k = 1; k < MAX_LAT; k++) begin
            if (int'(issue_lat_i) == k) busy = slot_q[k+1].valid;
        end
        accept  = request & legal & ~busy;
        error_o = request & (~legal | busy);
    end

    always_comb begin
        for (int k = 1; k < MAX_LAT; k++) slot_d[k] = slot_q[k+1];
        slot_d[MAX_LAT] = '0;
        for (int k = 1; k <= MAX_LAT; k++) begin
            if (accept && int'(issue_lat_i) == k) begin
                slot_d[k] = '{valid: 1'b1, tag: issue_tag_i};
            end
            if (flush_i) slot_d[k] = '0;
        end
        count_d = '0;
        for (int k = 2; k <= MAX_LAT; k++) begin
            count_d = count_d + LAT_WIDTH'(slot_d[k].valid);
        end
    end

    always_comb begin
        slot_free_o = '1;
        for (int l = 1; l < MAX_LAT; l++) begin
            slot_free_o[l-1] = ~slot_q[l+1].valid;
        end
    end

    assign bcast_valid_o = slot_q[1].valid;
    assign bcast_tag_o   = slot_q[1].valid ? slot_q[1].tag : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 1; k <= MAX_LAT; k++) slot_q[k] <= '0;
            inflight_o <= '0;
        end else begin
            for (int k = 1; k <= MAX_LAT; k++) slot_q[k] <= slot_d[k];
            inflight_o <= count_d;
        end
    end

endmodule

// File: rtl/wakeup_tag_broadcast.sv
// Issue-side wakeup bus transmitter: one latency slot pipe per issue lane,
// flattened port arrays and a sticky error flag.
module wakeup_tag_broadcast
    import wakeup_tag_broadcast_pkg::*;
#(
    parameter int ISSUE_LANES = DEF_ISSUE_LANES,
    parameter int TAG_WIDTH   = DEF_TAG_WIDTH,
    parameter int MAX_LAT     = DEF_MAX_LAT,
    parameter int LAT_WIDTH   = DEF_LAT_WIDTH
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush_i,
    input  logic [ISSUE_LANES-1:0]         issue_valid_i,
    input  logic [ISSUE_LANES-1:0]         issue_dest_valid_i,
    input  logic [ISSUE_LANES*TAG_WIDTH-1:0] issue_tag_i,
    input  logic [ISSUE_LANES*LAT_WIDTH-1:0] issue_lat_i,
    output logic [ISSUE_LANES*MAX_LAT-1:0] slot_free_o,
    output logic [ISSUE_LANES-1:0]         bcast_valid_o,
    output logic [ISSUE_LANES*TAG_WIDTH-1:0] bcast_tag_o,
    output logic [ISSUE_LANES*LAT_WIDTH-1:0] inflight_o,
    output logic                           error_o
);

    logic [ISSUE_LANES-1:0] lane_error;

    for (genvar n = 0; n < ISSUE_LANES; n++) begin : g_lane
        wakeup_lane_pipe #(
            .MAX_LAT   (MAX_LAT),
            .LAT_WIDTH (LAT_WIDTH)
        ) u_pipe (
            .clk                (clk),
            .reset              (reset),
            .flush_i            (flush_i),
            .issue_valid_i      (issue_valid_i[n]),
            .issue_dest_valid_i (issue_dest_valid_i[n]),
            .issue_tag_i        (issue_tag_i[n*TAG_WIDTH +: TAG_WIDTH]),
            .issue_lat_i        (issue_lat_i[n*LAT_WIDTH +: LAT_WIDTH]),
            .slot_free_o        (slot_free_o[n*MAX_LAT +: MAX_LAT]),
            .bcast_valid_o      (bcast_valid_o[n]),
            .bcast_tag_o        (bcast_tag_o[n*TAG_WIDTH +: TAG_WIDTH]),
            .inflight_o         (inflight_o[n*LAT_WIDTH +: LAT_WIDTH]),
            .error_o            (lane_error[n])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            error_o <= 1'b0;
        end else if (|lane_error) begin
            error_o <= 1'b1;
        end
    end

endmodule
